// File: rtl/logic_unit_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// out_popcnt exists only when LOGIC_UNIT_POPCOUNT_EN is defined.
interface logic_unit_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 32
);
  localparam int unsigned PCW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_zero;
  logic             out_ones;
  logic             out_parity;
`ifdef LOGIC_UNIT_POPCOUNT_EN
  logic [PCW-1:0]   out_popcnt;
`endif
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
`ifdef LOGIC_UNIT_POPCOUNT_EN
    input  out_popcnt,
`endif
    input  in_ready, out_valid, out_y, out_zero, out_ones, out_parity, op_count
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
`ifdef LOGIC_UNIT_POPCOUNT_EN
    output out_popcnt,
`endif
    output in_ready, out_valid, out_y, out_zero, out_ones, out_parity, op_count
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Handshaked 8-op bitwise logic unit with a 2-entry result buffer and flags.
// Optional per-result popcount: define LOGIC_UNIT_POPCOUNT_EN.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  logic_unit_if.slave bus
);
  localparam int unsigned PCW = $clog2(WIDTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             ones;
    logic             parity;
`ifdef LOGIC_UNIT_POPCOUNT_EN
    logic [PCW-1:0]   popcnt;
`endif
  } entry_t;

  entry_t           mem [2];
  logic             head;
  logic             tail;
  logic [1:0]       count;
  logic [CNT_W-1:0] op_count_q;
  entry_t           new_c;
  entry_t           head_c;
  logic             push_c;
  logic             pop_c;

  // Result and flags of the operand pair currently presented
  always_comb begin
    new_c = '0;
    case (bus.in_op)
      3'b000: new_c.y = bus.in_a & bus.in_b;
      3'b001: new_c.y = bus.in_a | bus.in_b;
      3'b010: new_c.y = bus.in_a ^ bus.in_b;
      3'b011: new_c.y = ~bus.in_a;
      3'b100: new_c.y = ~(bus.in_a & bus.in_b);
      3'b101: new_c.y = ~(bus.in_a | bus.in_b);
      3'b110: new_c.y = ~(bus.in_a ^ bus.in_b);
      3'b111: new_c.y = bus.in_a & ~bus.in_b;
    endcase
    new_c.zero   = ~|new_c.y;
    new_c.ones   = &new_c.y;
    new_c.parity = ^new_c.y;
`ifdef LOGIC_UNIT_POPCOUNT_EN
    for (int i = 0; i < int'(WIDTH); i++) begin
      new_c.popcnt = new_c.popcnt + PCW'(new_c.y[i]);
    end
`endif
  end

  // in_ready depends only on registered occupancy, never on out_ready
  assign bus.in_ready  = rst_n && (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign push_c        = bus.in_valid && bus.in_ready;
  assign pop_c         = bus.out_valid && bus.out_ready;

  assign head_c         = mem[head];
  assign bus.out_y      = head_c.y;
  assign bus.out_zero   = head_c.zero;
  assign bus.out_ones   = head_c.ones;
  assign bus.out_parity = head_c.parity;
`ifdef LOGIC_UNIT_POPCOUNT_EN
  assign bus.out_popcnt = head_c.popcnt;
`endif
  assign bus.op_count   = op_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0]     <= '0;
      mem[1]     <= '0;
      head       <= 1'b0;
      tail       <= 1'b0;
      count      <= 2'd0;
      op_count_q <= '0;
    end else begin
      if (push_c) begin
        mem[tail]  <= new_c;
        tail       <= ~tail;
        op_count_q <= op_count_q + CNT_W'(1);
      end
      if (pop_c) head <= ~head;
      case ({push_c, pop_c})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Stored flags must always agree with the stored result
  always @(posedge clk) begin
    if (rst_n && bus.out_valid) begin
      assert (head_c.zero == (~|head_c.y));
      assert (head_c.ones == (&head_c.y));
      assert (head_c.parity == (^head_c.y));
`ifdef LOGIC_UNIT_POPCOUNT_EN
      assert (head_c.popcnt == PCW'($countones(head_c.y)));
`endif
    end
  end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe; second instance with CNT_W=4 checks counter wrap.
module tb_logic_unit_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  logic_unit_if #(.WIDTH(32), .CNT_W(32)) bus ();
  logic_unit_if #(.WIDTH(32), .CNT_W(4))  bus4 ();

  logic_unit_pipe #(.WIDTH(32), .CNT_W(32)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic_unit_pipe #(.WIDTH(32), .CNT_W(4))  u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  assign bus4.in_valid  = bus.in_valid;
  assign bus4.in_op     = bus.in_op;
  assign bus4.in_a      = bus.in_a;
  assign bus4.in_b      = bus.in_b;
  assign bus4.out_ready = bus.out_ready;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
  endtask

  logic [31:0] sweep_exp [8];

  initial begin
    sweep_exp[0] = 32'h00F0_1200;
    sweep_exp[1] = 32'hFFF0_FF34;
    sweep_exp[2] = 32'hFF00_ED34;
    sweep_exp[3] = 32'h0F0F_EDCB;
    sweep_exp[4] = 32'hFF0F_EDFF;
    sweep_exp[5] = 32'h000F_00CB;
    sweep_exp[6] = 32'h00FF_12CB;
    sweep_exp[7] = 32'hF000_0034;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 3'b000;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_y", 64'(bus.out_y), 64'd0);
    check("rst_flags", 64'({bus.out_zero, bus.out_ones, bus.out_parity}), 64'd0);
    check("rst_op_count", 64'(bus.op_count), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
`ifdef LOGIC_UNIT_POPCOUNT_EN
    check("rst_popcnt", 64'(bus.out_popcnt), 64'd0);
`endif
    rst_n = 1'b1;
    #1;
    check("release_in_ready", 64'(bus.in_ready), 64'd1);

    // Op sweep, one result per cycle
    bus.out_ready = 1'b1;
    for (int op = 0; op < 8; op++) begin
      drive(3'(op), 32'hF0F0_1234, 32'h0FF0_FF00);
      tick();
      check($sformatf("sweep_op%0d", op), 64'(bus.out_y), 64'(sweep_exp[op]));
      check($sformatf("sweep_valid%0d", op), 64'(bus.out_valid), 64'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    check("sweep_drained", 64'(bus.out_valid), 64'd0);
    check("sweep_op_count", 64'(bus.op_count), 64'd8);

    // Flags
    drive(3'b000, 32'h1, 32'h2);
    tick();
    check("flag_and_y", 64'(bus.out_y), 64'd0);
    check("flag_and_zpo", 64'({bus.out_zero, bus.out_parity, bus.out_ones}), 64'b100);
    drive(3'b001, 32'hFFFF_FFFF, 32'h0);
    tick();
    check("flag_or_zpo", 64'({bus.out_zero, bus.out_parity, bus.out_ones}), 64'b001);
    drive(3'b010, 32'h7, 32'h0);
    tick();
    check("flag_xor_y", 64'(bus.out_y), 64'd7);
    check("flag_xor_zpo", 64'({bus.out_zero, bus.out_parity, bus.out_ones}), 64'b010);
`ifdef LOGIC_UNIT_POPCOUNT_EN
    check("flag_xor_popcnt", 64'(bus.out_popcnt), 64'd3);
`endif
    bus.in_valid = 1'b0;
    tick();
    check("flag_drained", 64'(bus.out_valid), 64'd0);

    // Back-pressure: third input waits until the buffer drains
    bus.out_ready = 1'b0;
    drive(3'b000, 32'h0000_00FF, 32'h0000_0F0F);
    tick();
    check("bp_ready_after1", 64'(bus.in_ready), 64'd1);
    drive(3'b001, 32'h0000_00FF, 32'h0000_0F0F);
    tick();
    check("bp_ready_full", 64'(bus.in_ready), 64'd0);
    check("bp_head0", 64'(bus.out_y), 64'h0F);
    drive(3'b010, 32'h0000_00FF, 32'h0000_0F0F);
    tick();
    check("bp_ready_still0", 64'(bus.in_ready), 64'd0);
    check("bp_head_stable", 64'(bus.out_y), 64'h0F);
    check("bp_op_count", 64'(bus.op_count), 64'd13);
    bus.out_ready = 1'b1;
    tick();
    check("bp_pop1", 64'(bus.out_y), 64'hFFF);
    check("bp_ready_again", 64'(bus.in_ready), 64'd1);
    tick();
    check("bp_pop2", 64'(bus.out_y), 64'hFF0);
    bus.in_valid = 1'b0;
    tick();
    check("bp_drained", 64'(bus.out_valid), 64'd0);
    check("bp_op_count_final", 64'(bus.op_count), 64'd14);

    // Simultaneous accept and pop at occupancy 1
    drive(3'b001, 32'h0000_0100, 32'h0);
    tick();
    for (int i = 1; i <= 10; i++) begin
      drive(3'b001, 32'h0000_0100 + 32'(i), 32'h0);
      tick();
      check($sformatf("sim_y%0d", i), 64'(bus.out_y), 64'h100 + 64'(i));
      check($sformatf("sim_ready%0d", i), 64'(bus.in_ready), 64'd1);
      check($sformatf("sim_valid%0d", i), 64'(bus.out_valid), 64'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    check("sim_drained", 64'(bus.out_valid), 64'd0);
    check("sim_op_count", 64'(bus.op_count), 64'd25);
    check("wrap4_pre", 64'(bus4.op_count), 64'd9);

    // Reset with a full buffer and pending handshakes
    bus.out_ready = 1'b0;
    drive(3'b111, 32'hFFFF_FFFF, 32'h0);
    tick();
    tick();
    check("full_before_rst", 64'(bus.in_ready), 64'd0);
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("rst2_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst2_out_y", 64'(bus.out_y), 64'd0);
    check("rst2_flags", 64'({bus.out_zero, bus.out_ones, bus.out_parity}), 64'd0);
    check("rst2_op_count", 64'(bus.op_count), 64'd0);
    check("rst2_in_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    #1;
    check("rst2_release_ready", 64'(bus.in_ready), 64'd1);

    // Counter wrap: 17 accepts
    for (int i = 0; i < 17; i++) begin
      drive(3'b010, 32'(i), 32'h5);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    check("wrap32_count", 64'(bus.op_count), 64'd17);
    check("wrap4_count", 64'(bus4.op_count), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
